// File: rtl/number_slot_scheduler.sv
// Twelve-slot number scheduler: fill, hit acceptance with lock, timed respawn.
// Optional NUMBER_SCHED_LFSR_EN selects an LFSR value generator.
module number_slot_scheduler #(
  parameter int RESPAWN_FRAMES = 60,
  parameter int MAX_VALUE      = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startOfFrame,
  input  logic             singleHit,
  input  logic [11:0]      hitVector,
  output logic [11:0][3:0] slotValue,
  output logic [11:0]      slotActive,
  output logic             hitValid,
  output logic [3:0]       hitSlot,
  output logic [3:0]       hitValue,
  output logic             allCleared
);

  typedef enum logic [1:0] {FILL, RUN, LOCK} state_t;

  localparam logic [7:0] RELOAD = 8'(RESPAWN_FRAMES);

  state_t           state;
  logic [3:0]       fidx;
  logic [11:0][7:0] cnt;
  logic [3:0]       gen_val;
  logic [11:0]      cand;
  logic [11:0]      pend;
  logic [3:0]       hit_idx;
  logic [3:0]       ref_idx;
  logic             hit_go;
  logic             ref_go;

  assign cand = hitVector & slotActive;

  always_comb begin
    hit_idx = '0;
    ref_idx = '0;
    pend    = '0;
    for (int i = 0; i < 12; i++)
      pend[i] = !slotActive[i] && (cnt[i] == 8'd0) && (state != FILL);
    // descending scan so the lowest set index wins
    for (int i = 11; i >= 0; i--) begin
      if (cand[i]) hit_idx = 4'(i);
      if (pend[i]) ref_idx = 4'(i);
    end
  end

  assign hit_go     = (state == RUN) && singleHit && (|cand);
  assign ref_go     = |pend;
  assign allCleared = (state == RUN) && (slotActive == 12'd0);

`ifdef NUMBER_SCHED_LFSR_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign gen_val = 4'(lfsr % 8'(MAX_VALUE + 1));
`else
  logic       consume;
  logic [3:0] gcnt;

  assign consume = (state == FILL) || ref_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      gcnt <= '0;
    else if (consume)
      gcnt <= (gcnt == 4'(MAX_VALUE)) ? 4'd0 : gcnt + 4'd1;
  end

  assign gen_val = gcnt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      fidx       <= '0;
      slotValue  <= '0;
      slotActive <= '0;
      hitValid   <= 1'b0;
      hitSlot    <= '0;
      hitValue   <= '0;
      cnt        <= '0;
    end else begin
      hitValid <= 1'b0;
      for (int i = 0; i < 12; i++) begin
        if (hit_go && hit_idx == 4'(i))
          cnt[i] <= RELOAD;
        else if (startOfFrame && !slotActive[i] && cnt[i] != 8'd0)
          cnt[i] <= cnt[i] - 8'd1;
      end
      if (ref_go) begin
        slotValue[ref_idx]  <= gen_val;
        slotActive[ref_idx] <= 1'b1;
      end
      unique case (state)
        FILL: begin
          slotValue[fidx]  <= gen_val;
          slotActive[fidx] <= 1'b1;
          if (fidx == 4'd11) begin
            state <= RUN;
            fidx  <= '0;
          end else begin
            fidx <= fidx + 4'd1;
          end
        end
        RUN: begin
          if (hit_go) begin
            slotActive[hit_idx] <= 1'b0;
            hitValid            <= 1'b1;
            hitSlot             <= hit_idx;
            hitValue            <= slotValue[hit_idx];
            state               <= LOCK;
          end
        end
        LOCK: begin
          if (!singleHit) state <= RUN;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_number_slot_scheduler.sv
// Scoreboard bench for number_slot_scheduler: slot-level reference model,
// directed scenarios followed by randomized hits and frame pulses.
module tb_number_slot_scheduler;

  localparam int RESP = 2;
  localparam int MAXV = 9;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             startOfFrame = 1'b0;
  logic             singleHit = 1'b0;
  logic [11:0]      hitVector = '0;
  logic [11:0][3:0] slotValue;
  logic [11:0]      slotActive;
  logic             hitValid;
  logic [3:0]       hitSlot;
  logic [3:0]       hitValue;
  logic             allCleared;

  number_slot_scheduler #(.RESPAWN_FRAMES(RESP), .MAX_VALUE(MAXV)) dut (
    .clk(clk),
    .reset(reset),
    .startOfFrame(startOfFrame),
    .singleHit(singleHit),
    .hitVector(hitVector),
    .slotValue(slotValue),
    .slotActive(slotActive),
    .hitValid(hitValid),
    .hitSlot(hitSlot),
    .hitValue(hitValue),
    .allCleared(allCleared)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction

  // reference model: slots as plain arrays, values from a consumption count
  typedef struct {int s; int v;} hit_t;
  hit_t q[$];
  int   mval[12];
  bit   mact[12];
  int   mcnt[12];
  int   nfill;
  bit   mlock;
  int   nused;
  int   mlast_s;
  int   mlast_v;

  function automatic void model_reset();
    for (int i = 0; i < 12; i++) begin
      mval[i] = 0;
      mact[i] = 0;
      mcnt[i] = 0;
    end
    nfill = 0;
    mlock = 0;
    nused = 0;
    mlast_s = 0;
    mlast_v = 0;
    q.delete();
  endfunction

  function automatic int nextval();
    int v;
    v = nused % (MAXV + 1);
    nused++;
    return v;
  endfunction

  function automatic void model_step();
    int h;
    int r;
    h = -1;
    r = -1;
    if (nfill < 12) begin
      mval[nfill] = nextval();
      mact[nfill] = 1;
      nfill++;
      return;
    end
    if (!mlock && singleHit)
      for (int i = 0; i < 12; i++)
        if (h < 0 && hitVector[i] && mact[i]) h = i;
    for (int i = 0; i < 12; i++)
      if (r < 0 && !mact[i] && mcnt[i] == 0) r = i;
    for (int i = 0; i < 12; i++) begin
      if (i == h) mcnt[i] = RESP;
      else if (startOfFrame && !mact[i] && mcnt[i] > 0) mcnt[i]--;
    end
    if (r >= 0) begin
      mval[r] = nextval();
      mact[r] = 1;
    end
    if (h >= 0) begin
      q.push_back('{h, mval[h]});
      mact[h] = 0;
      mlast_s = h;
      mlast_v = mval[h];
      mlock = 1;
    end else if (mlock && !singleHit) begin
      mlock = 0;
    end
  endfunction

  initial model_reset();

  always @(posedge clk) begin
    if (reset) model_reset();
    else       model_step();
  end

  // monitor: pops expected hits whenever the DUT shows one
  always @(negedge clk) begin
    logic [11:0] ea;
    logic [47:0] ev;
    bit          clr;
    hit_t        e;
    clr = (nfill >= 12) && !mlock;
    for (int i = 0; i < 12; i++) begin
      ea[i] = mact[i];
      ev[i*4 +: 4] = 4'(mval[i]);
      if (mact[i]) clr = 0;
    end
    chk("hitValid", hitValid, q.size() > 0);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("hitSlot", hitSlot, e.s);
      chk("hitValue", hitValue, e.v);
    end else begin
      chk("hitSlot_hold", hitSlot, mlast_s);
      chk("hitValue_hold", hitValue, mlast_v);
    end
    chk("slotActive", slotActive, ea);
    chk("slotValue", slotValue, ev);
    chk("allCleared", allCleared, clr);
  end

  task automatic cyc(input bit sh, input logic [11:0] hv, input bit sof);
    singleHit = sh;
    hitVector = hv;
    startOfFrame = sof;
    @(posedge clk);
    #1;
  endtask

  task automatic check_fill(string tag);
    chk({tag, "_active"}, slotActive, 12'hFFF);
    chk({tag, "_cleared"}, allCleared, 1'b0);
    for (int i = 0; i < 12; i++)
      chk({tag, "_val"}, slotValue[i], i % 10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    chk("rst_active", slotActive, 12'h000);
    chk("rst_values", slotValue, 48'h0);
    chk("rst_hitValid", hitValid, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) cyc(0, 12'h000, 0);
    check_fill("fill");

    // hit slot 4 with a frame pulse in the same cycle
    cyc(1, 12'h030, 1);
    chk("hit4_valid", hitValid, 1'b1);
    chk("hit4_slot", hitSlot, 4);
    chk("hit4_value", hitValue, 4);
    chk("hit4_active", slotActive, 12'hFEF);
    cyc(1, 12'h020, 1);
    chk("lock_no_hit", hitValid, 1'b0);
    cyc(1, 12'h020, 0);
    cyc(1, 12'h020, 0);
    chk("lock_no_hit2", hitValid, 1'b0);
    cyc(0, 12'h000, 1);
    cyc(0, 12'h000, 0);
    chk("respawn4_active", slotActive[4], 1'b1);
    chk("respawn4_value", slotValue[4], 2);
    cyc(1, 12'h020, 0);
    chk("hit5_valid", hitValid, 1'b1);
    chk("hit5_slot", hitSlot, 5);
    cyc(0, 12'h000, 0);

    // clear everything without frame pulses
    for (int k = 0; k < 12; k++) begin
      cyc(1, 12'hFFF, 0);
      cyc(0, 12'h000, 0);
    end
    chk("all_cleared", allCleared, 1'b1);
    chk("all_inactive", slotActive, 12'h000);
    cyc(0, 12'h000, 1);
    cyc(0, 12'h000, 1);
    for (int k = 0; k < 12; k++) begin
      cyc(0, 12'h000, 0);
      chk("refill_order", slotActive, (12'h1 << (k + 1)) - 1);
      chk("refill_not_cleared", allCleared, 1'b0);
    end

    // randomized hits and frame pulses
    for (int n = 0; n < 1500; n++)
      cyc(1'($urandom_range(0, 1)), 12'($urandom()),
          $urandom_range(0, 3) == 0);

    // reset asserted while in LOCK
    repeat (4) cyc(0, 12'h000, 1);
    for (int n = 0; n < 50 && !mlock; n++) cyc(1, 12'hFFF, 0);
    chk("reach_lock", mlock, 1'b1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("lockrst_active", slotActive, 12'h000);
    chk("lockrst_values", slotValue, 48'h0);
    chk("lockrst_hitValid", hitValid, 1'b0);
    chk("lockrst_hitSlot", hitSlot, 0);
    chk("lockrst_hitValue", hitValue, 0);
    chk("lockrst_cleared", allCleared, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) cyc(0, 12'h000, 0);
    check_fill("refill");
    repeat (3) cyc(0, 12'h000, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/number_slot_scheduler.md
NUMBER_SLOT_SCHEDULER -- requirements
Module: number_slot_scheduler

Interface
REQ-001 SHALL have parameter RESPAWN_FRAMES, default 60, meaning frames a hit slot stays empty before refill (legal 1..255).
REQ-002 SHALL have parameter MAX_VALUE, default 9, meaning the largest number value issued to a slot (legal 1..15).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port startOfFrame  input  1  one-cycle pulse per VGA frame.
REQ-006 SHALL have port singleHit  input  1  player-to-number collision level.
REQ-007 SHALL have port hitVector  input  12  per-slot drawing requests at the collision pixel.
REQ-008 SHALL have port slotValue  output  12x4  current value of each slot, fed to the number displays.
REQ-009 SHALL have port slotActive  output  12  slot visible and collidable.
REQ-010 SHALL have port hitValid  output  1  one-cycle pulse for each accepted hit.
REQ-011 SHALL have port hitSlot  output  4  index of the accepted hit slot, valid with hitValid.
REQ-012 SHALL have port hitValue  output  4  value of the accepted hit slot, valid with hitValid.
REQ-013 SHALL have port allCleared  output  1  high while no slot is active and the FSM is in RUN.

Function
REQ-014 FSM SHALL have states FILL, RUN, LOCK; reset enters FILL with fill index 0.
REQ-015 FILL SHALL write one slot per cycle, index 0..11: value from the generator, slotActive set; after slot 11 the FSM moves to RUN (12 cycles).
REQ-016 In RUN, a cycle with singleHit=1 and (hitVector & slotActive) non-zero SHALL accept a hit on the lowest-index set bit.
REQ-017 On an accepted hit, the next edge SHALL clear that slotActive bit, load its respawn counter with RESPAWN_FRAMES, pulse hitValid, drive hitSlot and hitValue (pre-hit value), and enter LOCK.
REQ-018 singleHit=1 with no active bit in hitVector SHALL be ignored; state stays RUN.
REQ-019 LOCK SHALL return to RUN on the first cycle with singleHit=0; no hit is accepted in LOCK.
REQ-020 Each startOfFrame SHALL decrement every non-zero respawn counter of an inactive slot, except a counter loaded in that same cycle.
REQ-021 A slot whose counter is 0 while inactive (outside FILL) SHALL be pending refill; one pending slot per cycle, lowest index first, SHALL receive a generator value and set slotActive.
REQ-022 Refill SHALL operate in both RUN and LOCK; a hit and a refill in the same cycle always target different slots.
REQ-023 Generator values SHALL lie in 0..MAX_VALUE; a value is consumed only when written to a slot.
REQ-024 allCleared SHALL be combinational from state and slotActive; hitValue/hitSlot SHALL hold between hits.

Reset
REQ-025 On reset assertion, regardless of the clock: slotValue all 0, slotActive 0, hitValid 0, hitSlot 0, hitValue 0, respawn counters 0, FSM FILL, generator at its seed.
REQ-026 Reset asserted mid-FILL or mid-LOCK SHALL abort the operation; FILL restarts at slot 0 after release.

Configuration
REQ-027 With NUMBER_SCHED_LFSR_EN defined, the generator SHALL be an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) advancing every clock, value = lfsr mod (MAX_VALUE+1).
REQ-028 Without NUMBER_SCHED_LFSR_EN, the generator SHALL be a counter 0..MAX_VALUE wrapping to 0, starting at 0 and advancing only on consumption.

Verification (macro undefined, RESPAWN_FRAMES=2, MAX_VALUE=9)
REQ-029 Release reset -> after 12 cycles slotActive=12'hFFF, slotValue = 0,1,...,9,0,1 for slots 0..11, allCleared=0.
REQ-030 RUN, singleHit=1, hitVector=12'h030 -> one hitValid pulse, hitSlot=4, hitValue=4, slotActive=12'hFEF, FSM in LOCK.
REQ-031 Hold singleHit=1 three cycles with hitVector=12'h020 -> no second hitValid; drop singleHit -> RUN, then hitVector=12'h020 accepted, hitSlot=5.
REQ-032 After hit on slot 4: startOfFrame in the same cycle leaves counter 2; two more startOfFrame pulses -> next cycle slot 4 active with value 2.
REQ-033 Hit all 12 slots in sequence -> allCleared=1 until the first refill; startOfFrame pulses then refill slots lowest index first, one per cycle.
REQ-034 Assert reset during LOCK -> all outputs 0 immediately; after release FILL repeats with slotValue starting at 0.
